mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single main-memory port between N_REQ processor tiles. Each tile drives out_request, in_grant and its memory enables, address and data.
- Grants one tile at a time using round-robin.
- While a tile is granted, the block routes that tile's memory enables, address and write data onto the shared memory port.
- Sits between the tile array and the memory model. Replaces tri-state sharing with an explicit mux.

Parameters:
- N_REQ, 4, number of requesting tiles (2..16)
- cell_width, 32, matrix cell width in bits
- size, 4, block dimension; width = cell_width*size = 128
- memory_size_log, 10, memory address width
- MAX_HOLD, 1024, hold-cycle count at which out_timeout raises
- HOLD_W, 16, width of the hold counter (saturating)

Ports:
- in_clk  input  1  clock
- in_reset  input  1  asynchronous, active-low reset
- in_request  input  N_REQ  per-tile request; held for the whole ownership
- out_grant  output  N_REQ  one-hot or zero, registered
- in_mem_write_en  input  N_REQ  per-tile write enable
- in_mem_read_en  input  N_REQ  per-tile read enable
- in_mem_address  input  N_REQ*memory_size_log  packed; tile i at bits [i*memory_size_log +: memory_size_log]
- in_mem_data  input  N_REQ*width  packed per-tile write data
- out_mem_write_en  output  1  shared memory write enable
- out_mem_read_en  output  1  shared memory read enable
- out_mem_address  output  memory_size_log  shared memory address
- out_mem_data  output  width  shared memory write data
- out_owner  output  $clog2(N_REQ)  index of the current owner; valid only when out_busy=1
- out_busy  output  1  high while in GRANT
- out_timeout  output  1  hold count >= MAX_HOLD and another tile is requesting

Behaviour:
- Reset is asynchronous, asserted on in_reset=0:
  - state=IDLE, rr_ptr=0, hold=0
  - out_grant=0, out_owner=0, out_busy=0, out_timeout=0
  - out_mem_* = 0
  - Takes effect immediately, mid-grant included. The grant drops without passing through RELEASE.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If in_request != 0: pick the first set bit scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - On the next edge: owner = winner, out_grant = one-hot(winner), state = GRANT, hold = 0.
  - Latency is 1 cycle from a sampled request to a visible grant.
- GRANT:
  - If in_request[owner]=1: stay; hold = hold+1, saturating at 2^HOLD_W-1.
  - If in_request[owner]=0: on the next edge out_grant=0, rr_ptr=(owner+1) mod N_REQ, state=RELEASE.
  - Requests from other tiles are ignored until IDLE.
- RELEASE: one turnaround cycle with no grant, then IDLE unconditionally.
  - Back-to-back handover costs 2 dead cycles: RELEASE, then arbitration in IDLE.
- The owner never loses its grant through arbitration. No preemption; out_timeout is status only.
- Shared port mux is combinational on the registered owner:
  - out_busy=1: out_mem_* = tile[owner] signals.
  - otherwise: out_mem_write_en=0, out_mem_read_en=0, address=0, data=0.
  - Enables from non-owners are ignored entirely. No contention is possible.
- If the owner asserts write_en and read_en together, both pass through unchanged; the memory's priority applies.
- Simultaneous events:
  - Owner drops its request while others raise theirs: RELEASE still occurs, and the next winner follows rr_ptr.
  - A requester that drops its request while in IDLE before the arbitration edge is not granted.
- rr_ptr wraps modulo N_REQ. With a single persistent requester, it is re-granted after RELEASE.
- out_timeout = (hold >= MAX_HOLD) && |(in_request & ~out_grant). Combinational from registered hold; clears on release.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding: IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2
  - localparam width = cell_width*size
  - function onehot(idx)
- Natural sub-module rr_picker: combinational. Inputs request vector and rr_ptr; outputs winner index and any_valid. Reused by future DMA arbitration.

Test Plan:
- Single request: in_request=4'b0001 sampled at edge k -> out_grant=0001 and out_busy=1 after edge k+1. Tile0 address 10'h3A0 with write_en=1 appears on out_mem_* in the same cycle.
- Round-robin: all four tiles request continuously, each dropping its request after 5 granted cycles -> grant order 0,1,2,3,0. Exactly 2 idle cycles between grants.
- Isolation: tile2 owns the port while tile1 drives write_en=1 and data=all-ones -> out_mem_write_en and out_mem_data follow tile2 only.
- Pointer wrap: rr_ptr=3 with requests 4'b1001 -> tile3 granted first, then tile0 after release.
- Timeout: MAX_HOLD=8, tile0 holds 8 cycles while tile1 requests -> out_timeout=1 from the 9th grant cycle. Grant is not revoked. out_timeout=0 once in RELEASE.
- Reset mid-grant: pull in_reset low during GRANT -> out_grant=0 and out_mem_*=0 without waiting for a clock edge. After reset release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the main-memory arbiter.
//   - FSM state encoding (IDLE / GRANT / RELEASE)
//   - default matrix-cell geometry and the derived data width
//   - onehot(): index -> one-hot grant vector (up to MAX_REQ tiles)
package mem_arb_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam int DEF_CELL_WIDTH = 32;
  localparam int DEF_SIZE       = 4;
  localparam int width          = DEF_CELL_WIDTH * DEF_SIZE;

  localparam int MAX_REQ = 16;

  function automatic logic [MAX_REQ-1:0] onehot(input int idx);
    logic [MAX_REQ-1:0] r;
    r = MAX_REQ'(1) << idx;
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
//   request   : N-bit request vector
//   ptr       : index with highest priority this round
//   winner    : first set request scanning ptr, ptr+1, ... mod N
//   any_valid : at least one request set (winner meaningless otherwise)
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  request,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          any_valid
);

  int            idx;
  logic [PW-1:0] k;

  // Scan from the farthest position back toward ptr so the nearest
  // requester (in rotated order) is the last one to write winner.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    k         = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      k   = PW'(idx);
      if (request[k]) begin
        winner    = k;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin owner of the shared main-memory port.
//   in_clk / in_reset      : clock, async active-low reset
//   in_request             : per-tile request, held for the whole ownership
//   out_grant              : registered one-hot grant (or zero)
//   in_mem_*               : per-tile memory enables / address / write data
//   out_mem_*              : shared port, muxed from the current owner
//   out_owner / out_busy   : owner index (valid while busy), busy = GRANT
//   out_timeout            : owner held >= MAX_HOLD cycles while others wait
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int cell_width      = DEF_CELL_WIDTH,
  parameter int size            = DEF_SIZE,
  parameter int memory_size_log = 10,
  parameter int MAX_HOLD        = 1024,
  parameter int HOLD_W          = 16,
  localparam int DW = cell_width * size,
  localparam int OW = $clog2(N_REQ)
) (
  input  logic                             in_clk,
  input  logic                             in_reset,
  input  logic [N_REQ-1:0]                 in_request,
  output logic [N_REQ-1:0]                 out_grant,
  input  logic [N_REQ-1:0]                 in_mem_write_en,
  input  logic [N_REQ-1:0]                 in_mem_read_en,
  input  logic [N_REQ*memory_size_log-1:0] in_mem_address,
  input  logic [N_REQ*DW-1:0]              in_mem_data,
  output logic                             out_mem_write_en,
  output logic                             out_mem_read_en,
  output logic [memory_size_log-1:0]       out_mem_address,
  output logic [DW-1:0]                    out_mem_data,
  output logic [OW-1:0]                    out_owner,
  output logic                             out_busy,
  output logic                             out_timeout
);

  logic [1:0]        state;
  logic [OW-1:0]     owner, rr_ptr, win;
  logic              any_req;
  logic [N_REQ-1:0]  grant;
  logic [HOLD_W-1:0] hold;

  // Unpacked per-tile views so the owner mux is a plain array index.
  logic [memory_size_log-1:0] addr_a [N_REQ];
  logic [DW-1:0]              data_a [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_view
    assign addr_a[i] = in_mem_address[i*memory_size_log +: memory_size_log];
    assign data_a[i] = in_mem_data[i*DW +: DW];
  end

  rr_picker #(.N(N_REQ), .PW(OW)) u_pick (
    .request   (in_request),
    .ptr       (rr_ptr),
    .winner    (win),
    .any_valid (any_req)
  );

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      grant  <= '0;
      hold   <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          owner <= win;
          grant <= N_REQ'(onehot(int'(win)));
          hold  <= '0;
          state <= GRANT;
        end
        GRANT: begin
          if (in_request[owner]) begin
            if (hold != {HOLD_W{1'b1}}) hold <= hold + 1'b1;
          end else begin
            grant  <= '0;
            hold   <= '0;   // timeout must read 0 during turnaround
            rr_ptr <= (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
            state  <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign out_grant = grant;
  assign out_owner = owner;
  assign out_busy  = (state == GRANT);

  // Non-owner enables never reach the port: everything is gated on busy.
  always_comb begin
    out_mem_write_en = 1'b0;
    out_mem_read_en  = 1'b0;
    out_mem_address  = '0;
    out_mem_data     = '0;
    if (out_busy) begin
      out_mem_write_en = in_mem_write_en[owner];
      out_mem_read_en  = in_mem_read_en[owner];
      out_mem_address  = addr_a[owner];
      out_mem_data     = data_a[owner];
    end
  end

  assign out_timeout = out_busy && (hold >= HOLD_W'(MAX_HOLD)) &&
                       ((in_request & ~grant) != '0);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter,
// checked every cycle against a transaction-level ownership model.
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 128;
  localparam int MH = 8;

  logic             in_clk = 1'b0;
  logic             in_reset;
  logic [N-1:0]     req, wen, ren;
  logic [N*AW-1:0]  addr;
  logic [N*DW-1:0]  data;
  logic [N-1:0]     out_grant;
  logic             out_mem_write_en, out_mem_read_en;
  logic [AW-1:0]    out_mem_address;
  logic [DW-1:0]    out_mem_data;
  logic [1:0]       out_owner;
  logic             out_busy, out_timeout;

  int checks = 0;
  int errors = 0;

  always #5 in_clk = ~in_clk;

  mem_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .in_clk           (in_clk),
    .in_reset         (in_reset),
    .in_request       (req),
    .out_grant        (out_grant),
    .in_mem_write_en  (wen),
    .in_mem_read_en   (ren),
    .in_mem_address   (addr),
    .in_mem_data      (data),
    .out_mem_write_en (out_mem_write_en),
    .out_mem_read_en  (out_mem_read_en),
    .out_mem_address  (out_mem_address),
    .out_mem_data     (out_mem_data),
    .out_owner        (out_owner),
    .out_busy         (out_busy),
    .out_timeout      (out_timeout)
  );

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner is -1 when nobody holds the port; 'dead' marks the turnaround
  // cycle after a release during which nobody can be picked.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_dead  = 1'b0;

  always @(posedge in_clk or negedge in_reset) begin
    int no, np, nh;
    bit nd;
    no = m_owner; np = m_ptr; nh = m_hold; nd = m_dead;
    if (!in_reset) begin
      no = -1; np = 0; nh = 0; nd = 1'b0;
    end else if (m_owner >= 0) begin
      if (req[m_owner]) nh = (m_hold < 65535) ? m_hold + 1 : m_hold;
      else begin
        np = (m_owner + 1) % N; no = -1; nh = 0; nd = 1'b1;
      end
    end else if (m_dead) begin
      nd = 1'b0;
    end else begin
      for (int k = 0; k < N; k++)
        if (no < 0 && req[(m_ptr + k) % N]) begin
          no = (m_ptr + k) % N; nh = 0;
        end
    end
    m_owner <= no; m_ptr <= np; m_hold <= nh; m_dead <= nd;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge in_clk) begin
    logic [N-1:0] eg;
    bit           eb, et;
    #2;
    eb = (m_owner >= 0);
    eg = eb ? N'(1) << m_owner : '0;
    et = eb && (m_hold >= MH) && ((req & ~eg) != 0);
    check("grant", DW'(out_grant), DW'(eg));
    check("busy", DW'(out_busy), DW'(eb));
    check("timeout", DW'(out_timeout), DW'(et));
    if (eb) begin
      check("owner", DW'(out_owner), DW'(m_owner));
      check("mem_we", DW'(out_mem_write_en), DW'(wen[m_owner]));
      check("mem_re", DW'(out_mem_read_en), DW'(ren[m_owner]));
      check("mem_addr", DW'(out_mem_address), DW'(addr[m_owner*AW +: AW]));
      check("mem_data", out_mem_data, data[m_owner*DW +: DW]);
    end else begin
      check("mem_idle", {out_mem_data[DW-1:AW+2] | out_mem_data[AW+1:0]
                         | {out_mem_address, out_mem_write_en, out_mem_read_en}}, '0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge in_clk);
    #3;
  endtask

  task automatic do_reset();
    in_reset = 1'b0;
    cyc();
    in_reset = 1'b1;
  endtask

  task automatic set_tile(input int i, input logic [AW-1:0] a, input logic w,
                          input logic r, input logic [DW-1:0] d);
    addr[i*AW +: AW] = a;
    wen[i] = w;
    ren[i] = r;
    data[i*DW +: DW] = d;
  endtask

  initial begin
    int got[$];
    int gaps[$];
    int cnt[N];
    int dead;
    bit prev_busy;
    in_reset = 1'b0;
    req = '0; wen = '0; ren = '0; addr = '0; data = '0;
    #1;
    check("rst_grant", DW'(out_grant), '0);
    check("rst_busy", DW'(out_busy), '0);
    check("rst_mem", {out_mem_data | DW'(out_mem_address)}, '0);
    cyc();
    in_reset = 1'b1;

    // Single request: visible one edge after it is sampled.
    set_tile(0, 10'h3A0, 1'b1, 1'b0, {4{32'hCAFE_0000}});
    req = 4'b0001;
    cyc();
    check("single_grant", DW'(out_grant), DW'(4'b0001));
    check("single_busy", DW'(out_busy), DW'(1'b1));
    check("single_addr", DW'(out_mem_address), DW'(10'h3A0));
    check("single_we", DW'(out_mem_write_en), DW'(1'b1));
    req = '0;
    cyc();
    check("single_release", DW'(out_grant), '0);
    cyc();

    // Round robin: everyone requests, each owner leaves after 5 cycles.
    do_reset();
    req = '1;
    dead = 0; prev_busy = 1'b0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < 200 && got.size() < 5; c++) begin
      cyc();
      if (!out_busy) dead++;
      else if (!prev_busy) begin
        got.push_back(int'(out_owner));
        if (got.size() > 1) gaps.push_back(dead);
        dead = 0;
      end
      prev_busy = out_busy;
      for (int i = 0; i < N; i++) begin
        if (out_grant[i]) begin
          cnt[i]++;
          if (cnt[i] == 5) begin req[i] = 1'b0; cnt[i] = 0; end
        end else req[i] = 1'b1;
      end
    end
    check("rr_count", DW'(got.size()), DW'(5));
    for (int k = 0; k < got.size(); k++) check("rr_order", DW'(got[k]), DW'(k % 4));
    for (int k = 0; k < gaps.size(); k++) check("rr_gap", DW'(gaps[k]), DW'(2));

    // Isolation: tile1 drives the bus while tile2 owns it.
    do_reset();
    req = '0; wen = '0; ren = '0;
    set_tile(2, 10'h155, 1'b0, 1'b1, {4{32'h0F0F_1234}});
    set_tile(1, 10'h2AA, 1'b1, 1'b0, '1);
    req = 4'b0100;
    cyc();
    check("iso_owner", DW'(out_owner), DW'(2));
    req[1] = 1'b1;
    cyc();
    check("iso_we", DW'(out_mem_write_en), DW'(1'b0));
    check("iso_data", out_mem_data, {4{32'h0F0F_1234}});
    check("iso_owner_kept", DW'(out_owner), DW'(2));

    // Pointer wrap: tile2 leaves -> ptr=3, requests 1001 -> 3 then 0.
    req = 4'b1001;
    cyc(); check("wrap_rel", DW'(out_grant), '0);
    cyc(); check("wrap_idle", DW'(out_grant), '0);
    cyc(); check("wrap_t3", DW'(out_grant), DW'(4'b1000));
    req = 4'b0001;
    cyc(); cyc();
    cyc(); check("wrap_t0", DW'(out_grant), DW'(4'b0001));

    // Timeout: tile0 holds while tile1 waits.
    do_reset();
    req = 4'b0011;
    for (int g = 1; g <= 10; g++) begin
      cyc();
      check("to_grant", DW'(out_grant), DW'(4'b0001));
      check("to_flag", DW'(out_timeout), DW'(g >= 9));
    end
    req[0] = 1'b0;
    cyc();
    check("to_release", DW'(out_timeout), '0);
    cyc(); cyc();
    check("to_next", DW'(out_grant), DW'(4'b0010));
    check("to_next_flag", DW'(out_timeout), '0);

    // Reset in the middle of a grant acts without a clock edge.
    do_reset();
    set_tile(1, 10'h3FF, 1'b1, 1'b1, '1);
    req = 4'b0010;
    cyc();
    check("mid_grant", DW'(out_grant), DW'(4'b0010));
    in_reset = 1'b0;
    #1;
    check("mid_rst_grant", DW'(out_grant), '0);
    check("mid_rst_en", DW'({out_mem_write_en, out_mem_read_en, out_busy}), '0);
    check("mid_rst_mem", {out_mem_data | DW'(out_mem_address)}, '0);
    cyc();
    in_reset = 1'b1;
    req = 4'b1111;
    cyc();
    check("post_rst_grant", DW'(out_grant), DW'(4'b0001));

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 1500; c++) begin
      cyc();
      for (int i = 0; i < N; i++) begin
        set_tile(i, AW'($urandom), 1'($urandom), 1'($urandom),
                 {$urandom, $urandom, $urandom, $urandom});
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      end
      if ($urandom_range(0, 399) == 0) begin
        in_reset = 1'b0;
        #1;
        check("rnd_rst", DW'({out_grant, out_busy}), '0);
        cyc();
        in_reset = 1'b1;
      end
    end

    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
